// File: rtl/trafficlight_pkg.sv
// Shared definitions for the two-light intersection controller and its monitor:
// phase encodings, monitor error codes, default 100 Hz dwell constants and the
// monitor FSM state type.
`timescale 1ns/1ps
package trafficlight_pkg;

    // Phase encodings shared with the controller; the sequence steps by +1 mod 4.
    typedef enum logic [1:0] {
        PhaseGR = 2'd0,
        PhaseYR = 2'd1,
        PhaseRG = 2'd2,
        PhaseRY = 2'd3
    } phase_e;

    // First-error codes reported by the monitor.
    typedef enum logic [2:0] {
        ErrNone      = 3'd0,
        ErrIllegal   = 3'd1,
        ErrSequence  = 3'd2,
        ErrUnderstay = 3'd3,
        ErrOverstay  = 3'd4
    } err_code_e;

    // Default dwell lengths at 100 Hz; green includes the terminal count cycle.
    localparam logic [15:0] GreenDwellDefault  = 16'd6001;
    localparam logic [15:0] YellowDwellDefault = 16'd501;

    typedef enum logic [1:0] {
        StSync  = 2'd0,
        StTrack = 2'd1,
        StFault = 2'd2
    } mon_state_e;

    // Only legal successor of a phase: GR->YR->RG->RY->GR.
    function automatic phase_e next_phase(input phase_e cur);
        return phase_e'(cur + 2'd1);
    endfunction

endpackage

// File: rtl/trafficlight_phase_decoder.sv
// Combinational decode of the six lamp lines into a phase and a legality flag.
// Anything other than the four legal lamp patterns reports phase_valid = 0.
`timescale 1ns/1ps
module trafficlight_phase_decoder
    import trafficlight_pkg::*;
(
    input  logic   l1_g,
    input  logic   l1_y,
    input  logic   l1_r,
    input  logic   l2_g,
    input  logic   l2_y,
    input  logic   l2_r,
    output phase_e phase,
    output logic   phase_valid
);

    logic [5:0] lamps;
    assign lamps = {l1_g, l1_y, l1_r, l2_g, l2_y, l2_r};

    // Exactly one lamp lit per light, and never both lights non-red.
    always_comb begin
        phase       = PhaseGR;
        phase_valid = 1'b1;
        case (lamps)
            6'b100_001: phase = PhaseGR;
            6'b010_001: phase = PhaseYR;
            6'b001_100: phase = PhaseRG;
            6'b001_010: phase = PhaseRY;
            default:    phase_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/trafficlight_monitor.sv
// Receive-side checker for the intersection controller's lamp outputs.
// Registers the lamps, decodes them into a phase, tracks phase order and per-phase
// dwell, and reports illegal combinations, out-of-order phases and dwell violations.
// Build option: define TLMON_AUTO_RESYNC_EN to return to SYNC after any error
// instead of parking in FAULT until clr_err.
`timescale 1ns/1ps
module trafficlight_monitor
    import trafficlight_pkg::*;
#(
    parameter logic [15:0] GREEN_DWELL_CC  = GreenDwellDefault,
    parameter logic [15:0] YELLOW_DWELL_CC = YellowDwellDefault,
    parameter logic [15:0] TOL_CC          = 16'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr_err,
    input  logic        l1_g,
    input  logic        l1_y,
    input  logic        l1_r,
    input  logic        l2_g,
    input  logic        l2_y,
    input  logic        l2_r,
    output logic [1:0]  phase,
    output logic        phase_valid,
    output logic        err_illegal,
    output logic        err_sequence,
    output logic        err_timing,
    output logic        err_sticky,
    output logic [2:0]  err_code,
    output logic [15:0] cycle_count
);

    // Dwell windows with clamping at both ends of the 16-bit range.
    localparam logic [16:0] GreenSum  = {1'b0, GREEN_DWELL_CC} + {1'b0, TOL_CC};
    localparam logic [16:0] YellowSum = {1'b0, YELLOW_DWELL_CC} + {1'b0, TOL_CC};
    localparam logic [15:0] GreenHi   = GreenSum[16] ? 16'hFFFF : GreenSum[15:0];
    localparam logic [15:0] YellowHi  = YellowSum[16] ? 16'hFFFF : YellowSum[15:0];
    localparam logic [15:0] GreenLo   =
        (GREEN_DWELL_CC >= TOL_CC) ? GREEN_DWELL_CC - TOL_CC : 16'd0;
    localparam logic [15:0] YellowLo  =
        (YELLOW_DWELL_CC >= TOL_CC) ? YELLOW_DWELL_CC - TOL_CC : 16'd0;

    logic [5:0]  lamp_q;
    phase_e      dec_phase;
    logic        dec_valid;

    mon_state_e  state_q, state_d;
    phase_e      phase_q;
    logic        phase_valid_q;
    logic [15:0] dwell_q, dwell_d;
    logic        partial_q, partial_d;
    logic        ill_d, seq_d, tim_d;
    logic        ill_q, seq_q, tim_q;
    logic        sticky_q, sticky_d;
    err_code_e   code_q, code_d;
    logic [15:0] cycle_q, cycle_d;

    logic        tracking, phase_change, under, over, any_err;
    logic [15:0] win_lo, win_hi;

    trafficlight_phase_decoder u_decoder (
        .l1_g        (lamp_q[5]),
        .l1_y        (lamp_q[4]),
        .l1_r        (lamp_q[3]),
        .l2_g        (lamp_q[2]),
        .l2_y        (lamp_q[1]),
        .l2_r        (lamp_q[0]),
        .phase       (dec_phase),
        .phase_valid (dec_valid)
    );

    // State register plus all datapath registers; async active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lamp_q        <= '0;
            state_q       <= StSync;
            phase_q       <= PhaseGR;
            phase_valid_q <= 1'b0;
            dwell_q       <= '0;
            partial_q     <= 1'b1;
            ill_q         <= 1'b0;
            seq_q         <= 1'b0;
            tim_q         <= 1'b0;
            sticky_q      <= 1'b0;
            code_q        <= ErrNone;
            cycle_q       <= '0;
        end else begin
            lamp_q        <= {l1_g, l1_y, l1_r, l2_g, l2_y, l2_r};
            state_q       <= state_d;
            phase_q       <= dec_phase;
            phase_valid_q <= dec_valid;
            dwell_q       <= dwell_d;
            partial_q     <= partial_d;
            ill_q         <= ill_d;
            seq_q         <= seq_d;
            tim_q         <= tim_d;
            sticky_q      <= sticky_d;
            code_q        <= code_d;
            cycle_q       <= cycle_d;
        end
    end

    // Phase-change detection, dwell counting and error classification.
    always_comb begin
        tracking     = en && (state_q == StTrack);
        phase_change = dec_valid && (!phase_valid_q || (dec_phase != phase_q));
        if ((phase_q == PhaseGR) || (phase_q == PhaseRG)) begin
            win_lo = GreenLo;
            win_hi = GreenHi;
        end else begin
            win_lo = YellowLo;
            win_hi = YellowHi;
        end
        if (phase_change) begin
            dwell_d = 16'd1;
        end else if (dwell_q == 16'hFFFF) begin
            dwell_d = dwell_q;
        end else begin
            dwell_d = dwell_q + 16'd1;
        end
        // First phase after SYNC entered mid-dwell, so its exit is not judged.
        if (state_q != StTrack) begin
            partial_d = 1'b1;
        end else if (phase_change) begin
            partial_d = 1'b0;
        end else begin
            partial_d = partial_q;
        end
        ill_d   = tracking && !dec_valid;
        seq_d   = tracking && phase_change && (dec_phase != next_phase(phase_q));
        under   = tracking && phase_change && !partial_q && (dwell_q < win_lo);
        // Equality on the step past the window fires once; a clamped window never fires.
        over    = tracking && dec_valid && !phase_change &&
                  (win_hi != 16'hFFFF) && (dwell_q == win_hi);
        tim_d   = under || over;
        any_err = ill_d || seq_d || tim_d;
    end

    // Next-state logic for SYNC / TRACK / FAULT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StSync: begin
                if (dec_valid) begin
                    state_d = StTrack;
                end
            end
            StTrack: begin
                if (any_err) begin
`ifdef TLMON_AUTO_RESYNC_EN
                    state_d = StSync;
`else
                    state_d = StFault;
`endif
                end
            end
            StFault: begin
                if (clr_err) begin
                    state_d = StSync;
                end
            end
            default: state_d = StSync;
        endcase
        if (!en) begin
            state_d = StSync;
        end
    end

    // Sticky flag, first-error code capture and completed-cycle counter.
    always_comb begin
        sticky_d = sticky_q;
        code_d   = code_q;
        cycle_d  = cycle_q;
        if (any_err) begin
            sticky_d = 1'b1;
        end else if (clr_err) begin
            sticky_d = 1'b0;
        end
        // A new error in the clearing cycle becomes the first error of the new window.
        if (any_err && (!sticky_q || clr_err)) begin
            if (ill_d) begin
                code_d = ErrIllegal;
            end else if (seq_d) begin
                code_d = ErrSequence;
            end else if (under) begin
                code_d = ErrUnderstay;
            end else begin
                code_d = ErrOverstay;
            end
        end else if (clr_err) begin
            code_d = ErrNone;
        end
        if (tracking && phase_change && !any_err &&
            (phase_q == PhaseRY) && (dec_phase == PhaseGR)) begin
            cycle_d = cycle_q + 16'd1;
        end
    end

    assign phase        = phase_q;
    assign phase_valid  = phase_valid_q;
    assign err_illegal  = ill_q;
    assign err_sequence = seq_q;
    assign err_timing   = tim_q;
    assign err_sticky   = sticky_q;
    assign err_code     = code_q;
    assign cycle_count  = cycle_q;

endmodule

// File: tb/tb_trafficlight_monitor.sv
// Directed bench for trafficlight_monitor at the default 6001/501/0 dwell settings.
`timescale 1ns/1ps
module tb_trafficlight_monitor;

    localparam logic [5:0] LampGR  = 6'b100_001;
    localparam logic [5:0] LampYR  = 6'b010_001;
    localparam logic [5:0] LampRG  = 6'b001_100;
    localparam logic [5:0] LampRY  = 6'b001_010;
    localparam logic [5:0] LampBad = 6'b101_001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        clr_err = 1'b0;
    logic        l1_g = 1'b0, l1_y = 1'b0, l1_r = 1'b0;
    logic        l2_g = 1'b0, l2_y = 1'b0, l2_r = 1'b0;
    logic [1:0]  phase;
    logic        phase_valid;
    logic        err_illegal, err_sequence, err_timing, err_sticky;
    logic [2:0]  err_code;
    logic [15:0] cycle_count;

    int n_checks = 0;
    int n_errors = 0;
    int n_ill = 0;
    int n_seq = 0;
    int n_tim = 0;

    trafficlight_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .clr_err      (clr_err),
        .l1_g         (l1_g),
        .l1_y         (l1_y),
        .l1_r         (l1_r),
        .l2_g         (l2_g),
        .l2_y         (l2_y),
        .l2_r         (l2_r),
        .phase        (phase),
        .phase_valid  (phase_valid),
        .err_illegal  (err_illegal),
        .err_sequence (err_sequence),
        .err_timing   (err_timing),
        .err_sticky   (err_sticky),
        .err_code     (err_code),
        .cycle_count  (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: sample 1 time unit after the edge and tally error pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        n_ill += int'(err_illegal);
        n_seq += int'(err_sequence);
        n_tim += int'(err_timing);
    endtask

    task automatic set_lamps(input logic [5:0] v);
        {l1_g, l1_y, l1_r, l2_g, l2_y, l2_r} = v;
    endtask

    task automatic hold(input logic [5:0] v, input int n);
        set_lamps(v);
        repeat (n) tick();
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b1;
        #2;
        check_eq({tag, "_flags"}, {30'd0, phase_valid, err_sticky}, 32'd0);
        check_eq({tag, "_pulses"}, {29'd0, err_illegal, err_sequence, err_timing}, 32'd0);
        check_eq({tag, "_phase_code"}, {27'd0, phase, err_code}, 32'd0);
        check_eq({tag, "_cycles"}, {16'd0, cycle_count}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        en = 1'b1;
        clr_err = 1'b0;
        n_ill = 0;
        n_seq = 0;
        n_tim = 0;
    endtask

    int first_at;

    initial begin
        // 1: three full cycles at nominal dwell
        apply_reset("rst0");
        hold(LampGR, 6001);
        check_eq("t1_phase_gr", {30'd0, phase}, 32'd0);
        check_eq("t1_valid_gr", {31'd0, phase_valid}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            hold(LampYR, 501);
            check_eq("t1_phase_yr", {30'd0, phase}, 32'd1);
            hold(LampRG, 6001);
            check_eq("t1_phase_rg", {30'd0, phase}, 32'd2);
            hold(LampRY, 501);
            check_eq("t1_phase_ry", {30'd0, phase}, 32'd3);
            hold(LampGR, 6001);
            check_eq("t1_cycles", {16'd0, cycle_count}, c + 1);
        end
        check_eq("t1_no_pulses", n_ill + n_seq + n_tim, 32'd0);
        check_eq("t1_code", {29'd0, err_code}, 32'd0);
        check_eq("t1_sticky", {31'd0, err_sticky}, 32'd0);

        // 2: illegal combination, exact 2-clock latency, single-cycle pulse
        apply_reset("rst1");
        hold(LampGR, 5);
        set_lamps(LampBad);
        tick();
        check_eq("t2_ill_early", {31'd0, err_illegal}, 32'd0);
        tick();
        check_eq("t2_ill_pulse", {31'd0, err_illegal}, 32'd1);
        check_eq("t2_code", {29'd0, err_code}, 32'd1);
        check_eq("t2_sticky", {31'd0, err_sticky}, 32'd1);
        check_eq("t2_invalid", {31'd0, phase_valid}, 32'd0);
        tick();
        check_eq("t2_ill_single", {31'd0, err_illegal}, 32'd0);

        // 3: GR straight to RG, then a later illegal keeps the first code
        apply_reset("rst2");
        hold(LampGR, 6001);
        hold(LampRG, 2);
        check_eq("t3_seq_pulse", {31'd0, err_sequence}, 32'd1);
        check_eq("t3_no_timing", {31'd0, err_timing}, 32'd0);
        check_eq("t3_code", {29'd0, err_code}, 32'd2);
        hold(LampRG, 3);
        en = 1'b0;
        tick();
        en = 1'b1;
        hold(LampRG, 3);
        hold(LampBad, 2);
        check_eq("t3_ill_retrack", {31'd0, err_illegal}, 32'd1);
        check_eq("t3_code_kept", {29'd0, err_code}, 32'd2);

        // 4: yellow understay on exit
        apply_reset("rst3");
        hold(LampGR, 10);
        hold(LampYR, 400);
        hold(LampRG, 2);
        check_eq("t4_timing_pulse", {31'd0, err_timing}, 32'd1);
        check_eq("t4_no_seq", n_seq, 32'd0);
        check_eq("t4_code", {29'd0, err_code}, 32'd3);

        // 5: green overstay fires once, on the edge where dwell reaches 6002
        apply_reset("rst4");
        set_lamps(LampGR);
        first_at = 0;
        for (int i = 1; i <= 6010; i++) begin
            tick();
            if (err_timing && (first_at == 0)) first_at = i;
        end
        check_eq("t5_timing_count", n_tim, 32'd1);
        check_eq("t5_timing_edge", first_at, 32'd6003);
        check_eq("t5_other_pulses", n_ill + n_seq, 32'd0);
        check_eq("t5_code", {29'd0, err_code}, 32'd4);

        // 6: clear and new illegal in the same cycle; new error wins
        en = 1'b0;
        tick();
        en = 1'b1;
        hold(LampGR, 3);
        set_lamps(LampBad);
        tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check_eq("t6_ill_pulse", {31'd0, err_illegal}, 32'd1);
        check_eq("t6_sticky", {31'd0, err_sticky}, 32'd1);
        check_eq("t6_code", {29'd0, err_code}, 32'd1);

        // 6b: asynchronous reset mid-RG
        hold(LampRG, 20);
        check_eq("t6_pre_rst_phase", {30'd0, phase}, 32'd2);
        #3;
        rst = 1'b1;
        #1;
        check_eq("t6_rst_phase", {30'd0, phase}, 32'd0);
        check_eq("t6_rst_valid", {31'd0, phase_valid}, 32'd0);
        check_eq("t6_rst_sticky", {31'd0, err_sticky}, 32'd0);
        check_eq("t6_rst_code", {29'd0, err_code}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_ill = 0;
        n_seq = 0;
        n_tim = 0;
        hold(LampRG, 3);
        check_eq("t6_resume_phase", {30'd0, phase}, 32'd2);
        check_eq("t6_resume_valid", {31'd0, phase_valid}, 32'd1);
        check_eq("t6_resume_quiet", n_ill + n_seq + n_tim, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
